param_insert_sort: RTL and testbench

- Parametrised successor to the team's fixed 8×32 insertion sorter.
- Generalised in data width, depth and signedness. Sort direction is selectable per run.
- Uses valid/ready handshakes on both the load and the drain side, so it can sit between streaming producers and consumers in the lab datapath.
- Same in-place insertion algorithm: one compare-or-swap per clock.

---
 rtl/param_insert_sort.sv | 197 +++++++++++++++++++
 tb/tb_param_insert_sort.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_insert_sort.sv
// param_insert_sort: streaming in-place insertion sorter.
// A batch of DEPTH words is loaded over a valid/ready port, sorted with one
// compare-or-swap per clock, then drained over a valid/ready port.
// Optional build macro INSERT_SORT_STATS_EN adds a swap_count output.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | accepting DEPTH words into a[]
// SORT   | one compare-or-swap (or index advance) per clock
// OUT    | presenting a[k] until its handshake
module param_insert_sort #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 8,
    parameter int SIGNED = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             descending,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
`ifdef INSERT_SORT_STATS_EN
    ,
    output logic [$clog2(DEPTH*(DEPTH-1)/2+1)-1:0] swap_count
`endif
);

    localparam int IW = $clog2(DEPTH);
    localparam int JW = IW + 1;
    localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_SORT = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [IW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        i_q, i_d;
    logic [IW-1:0]        k_q, k_d;
    logic signed [JW-1:0] j_q, j_d;
    logic signed [JW-1:0] j_p1;
    logic                 mode_q, mode_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     a_q [DEPTH];
    logic [WIDTH-1:0]     a_d [DEPTH];

    logic [WIDTH-1:0]     aj, aj1;
    logic                 gt, lt, ooo;
    logic                 i_last, do_swap;

    assign j_p1    = j_q + JW'(1);
    assign i_last  = (i_q == LAST);
    assign do_swap = (state_q == S_SORT) && !i_last && !j_q[JW-1] && ooo;

    // Fetch the adjacent pair a[j], a[j+1] under test this cycle.
    always_comb begin
        aj  = '0;
        aj1 = '0;
        for (int n = 0; n < DEPTH; n++) begin
            if (j_q == JW'(n))  aj  = a_q[n];
            if (j_p1 == JW'(n)) aj1 = a_q[n];
        end
    end

    // Out-of-order test: a[j] > a[j+1] ascending, a[j] < a[j+1] descending.
    always_comb begin
        if (SIGNED != 0) begin
            gt = $signed(aj) > $signed(aj1);
            lt = $signed(aj) < $signed(aj1);
        end else begin
            gt = aj > aj1;
            lt = aj < aj1;
        end
        ooo = mode_q ? lt : gt;
    end

    // Next-state, index and array update logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        a_d     = a_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = descending;
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    a_d[cnt_q] = in_data;
                    if (cnt_q == LAST) begin
                        state_d = S_SORT;
                        i_d     = '0;
                        j_d     = '0;
                    end else begin
                        cnt_d = cnt_q + IW'(1);
                    end
                end
            end
            S_SORT: begin
                if (do_swap) begin
                    for (int n = 0; n < DEPTH; n++) begin
                        if (j_q == JW'(n))       a_d[n] = aj1;
                        else if (j_p1 == JW'(n)) a_d[n] = aj;
                    end
                    j_d = j_q - JW'(1);
                end else if (!i_last) begin
                    i_d = i_q + IW'(1);
                    j_d = {1'b0, i_q + IW'(1)};
                end else begin
                    state_d = S_OUT;
                    k_d     = '0;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    if (k_q == LAST) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        k_d = k_q + IW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers with asynchronous abort.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    // Word storage; contents are meaningless until a batch is loaded.
    always_ff @(posedge clk) begin
        a_q <= a_d;
    end

    assign in_ready  = (state_q == S_LOAD);
    assign out_valid = (state_q == S_OUT);
    assign out_data  = out_valid ? a_q[k_q] : '0;
    assign out_last  = out_valid && (k_q == LAST);
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;

`ifdef INSERT_SORT_STATS_EN
    localparam int SW = $clog2(DEPTH*(DEPTH-1)/2+1);
    logic [SW-1:0] swap_q, swap_d;

    // Swap counter: cleared on accepted start, bumped on every swap.
    always_comb begin
        swap_d = swap_q;
        if (state_q == S_IDLE && start) swap_d = '0;
        else if (do_swap)               swap_d = swap_q + SW'(1);
    end

    // Swap counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) swap_q <= '0;
        else        swap_q <= swap_d;
    end

    assign swap_count = swap_q;
`endif

endmodule

// File: tb/tb_param_insert_sort.sv
// Testbench for param_insert_sort: a signed and an unsigned instance share
// load-side stimulus; results are compared with a rank-based stable sort model.
module tb_param_insert_sort;
    localparam int W = 32;
    localparam int D = 8;

    logic clk = 1'b0;
    logic reset, start, descending, in_valid, out_ready;
    logic [W-1:0] in_data;
    logic in_ready, out_valid, out_last, busy, done;
    logic [W-1:0] out_data;
    logic u_in_ready, u_out_valid, u_out_last, u_busy, u_done;
    logic [W-1:0] u_out_data;
    logic u_out_ready = 1'b1;
`ifdef INSERT_SORT_STATS_EN
    logic [4:0] swap_count, u_swap_count;
`endif

    param_insert_sort #(.WIDTH(W), .DEPTH(D), .SIGNED(1)) dut (
        .clk(clk), .reset(reset), .start(start), .descending(descending),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .busy(busy), .done(done)
`ifdef INSERT_SORT_STATS_EN
        , .swap_count(swap_count)
`endif
    );

    param_insert_sort #(.WIDTH(W), .DEPTH(D), .SIGNED(0)) dut_u (
        .clk(clk), .reset(reset), .start(start), .descending(descending),
        .in_valid(in_valid), .in_data(in_data), .in_ready(u_in_ready),
        .out_valid(u_out_valid), .out_data(u_out_data), .out_last(u_out_last),
        .out_ready(u_out_ready), .busy(u_busy), .done(u_done)
`ifdef INSERT_SORT_STATS_EN
        , .swap_count(u_swap_count)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] ld [D];
    logic [W-1:0] got [D];
    logic [W-1:0] exp_v [D];
    logic [W-1:0] uq [$];
    int sort_cyc, last_cnt, last_pos, stall_err, zero_err;
    bit done_ok, tmo;

    // unsigned instance drains freely; capture every word it presents
    always @(negedge clk) if (u_out_valid) uq.push_back(u_out_data);

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    function automatic bit ooo(input logic [W-1:0] a, input logic [W-1:0] b,
                               input bit desc, input bit sgn);
        if (sgn) return desc ? ($signed(a) < $signed(b)) : ($signed(a) > $signed(b));
        return desc ? (a < b) : (a > b);
    endfunction

    // stable sort by rank: element p lands after every word that must precede it
    task automatic model(input bit desc, input bit sgn);
        int rank;
        for (int p = 0; p < D; p++) begin
            rank = 0;
            for (int q = 0; q < D; q++)
                if (ooo(ld[p], ld[q], desc, sgn) || (ld[q] == ld[p] && q < p)) rank++;
            exp_v[rank] = ld[p];
        end
    endtask

    function automatic int inversions(input bit desc, input bit sgn);
        int c = 0;
        for (int p = 0; p < D; p++)
            for (int q = p + 1; q < D; q++)
                if (ooo(ld[p], ld[q], desc, sgn)) c++;
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_batch(input bit desc);
        start = 1'b1;
        descending = desc;
        tick();
        start = 1'b0;
        descending = 1'b0;
    endtask

    task automatic load_words(input bit gaps, input bit abuse);
        int n = 0;
        int guard = 0;
        bit acc;
        while (n < D && guard < 1000) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data = ld[n];
            if (abuse) start = 1'($urandom_range(0, 1));
            acc = in_valid && in_ready;
            tick();
            if (acc) n++;
            guard++;
        end
        if (n < D) tmo = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        start = 1'b0;
    endtask

    task automatic wait_sort(input bit abuse);
        int guard = 0;
        sort_cyc = 0;
        while (!out_valid && guard < 200) begin
            if (busy && !in_ready) sort_cyc++;
            if (out_data !== '0) zero_err++;
            if (abuse) begin
                start = 1'b1;
                in_valid = 1'b1;
                in_data = $urandom;
            end
            tick();
            guard++;
        end
        if (!out_valid) tmo = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
    endtask

    task automatic drain(input bit toggle, input bit abuse, input int max_words);
        int m = 0;
        int guard = 0;
        int c = 0;
        bit hs;
        bit stalled = 1'b0;
        logic [W-1:0] pd;
        logic pl;
        last_cnt = 0;
        last_pos = -1;
        stall_err = 0;
        done_ok = 1'b0;
        while (m < max_words && guard < 1000) begin
            out_ready = toggle ? (c % 2 == 0) : 1'b1;
            if (abuse) start = 1'($urandom_range(0, 1));
            if (stalled && (out_data !== pd || out_last !== pl)) stall_err++;
            if (!out_valid) begin
                tmo = 1'b1;
                break;
            end
            hs = out_ready;
            pd = out_data;
            pl = out_last;
            if (hs) begin
                got[m] = out_data;
                if (out_last) begin
                    last_cnt++;
                    last_pos = m;
                end
                m++;
            end
            stalled = !out_ready;
            tick();
            c++;
            guard++;
            if (hs && pl) begin
                start = 1'b0;
                done_ok = (done === 1'b1) && (busy === 1'b0) && (out_valid === 1'b0);
                tick();
                done_ok = done_ok && (done === 1'b0);
                break;
            end
        end
        if (m < max_words) tmo = 1'b1;
        start = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic run_batch(input bit desc, input bit gaps, input bit toggle, input bit abuse);
        tmo = 1'b0;
        zero_err = 0;
        begin_batch(desc);
        load_words(gaps, abuse);
        wait_sort(abuse);
        drain(toggle, abuse, D);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        checks++;
        if ({in_ready, out_valid, out_last, busy, done} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 00000", {in_ready, out_valid, out_last, busy, done});
        end
        checks++;
        if (out_data !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h required 0", out_data);
        end
        tick();
        @(negedge clk);
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: busy %b in_ready %b required 0 0", busy, in_ready);
        end
    endtask

    task automatic test_basic();
        int bad = 0;
        ld = '{32'd5, 32'd3, 32'd8, 32'd1, 32'd9, 32'd2, 32'd7, 32'd4};
        model(1'b0, 1'b1);
        run_batch(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (tmo !== 1'b0) begin errors++; $display("FAIL basic_timeout: got %b required 0", tmo); end
        for (int m = 0; m < D; m++) begin
            checks++;
            if (got[m] !== exp_v[m]) begin
                errors++;
                $display("FAIL basic_word%0d: got %0d required %0d", m, got[m], exp_v[m]);
            end
        end
        checks++;
        if (last_cnt !== 1 || last_pos !== D - 1) begin
            errors++;
            $display("FAIL basic_last: count %0d pos %0d required 1 at %0d", last_cnt, last_pos, D - 1);
        end
        checks++;
        if (done_ok !== 1'b1) begin errors++; $display("FAIL basic_done: got %b required 1", done_ok); end
        checks++;
        if (zero_err !== 0) begin errors++; $display("FAIL basic_outdata_zero: got %0d nonzero required 0", zero_err); end
        bad = bad;
    endtask

    task automatic test_signedness();
        int guard = 0;
        int bad = 0;
        while (u_busy && guard < 500) begin tick(); guard++; end
        ld = '{32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFB, 32'd7, 32'hFFFF_FFFB, 32'd3, 32'd1};
        uq.delete();
        model(1'b0, 1'b1);
        run_batch(1'b0, 1'b0, 1'b0, 1'b0);
        for (int m = 0; m < D; m++) if (got[m] !== exp_v[m]) bad++;
        checks++;
        if (bad != 0 || tmo) begin
            errors++;
            $display("FAIL signed_order: got %h..%h required %h..%h (bad %0d)", got[0], got[D-1], exp_v[0], exp_v[D-1], bad);
        end
        guard = 0;
        while (u_busy && guard < 500) begin tick(); guard++; end
        model(1'b0, 1'b0);
        checks++;
        if (uq.size() != D) begin
            errors++;
            $display("FAIL unsigned_count: got %0d required %0d", uq.size(), D);
        end else begin
            bad = 0;
            for (int m = 0; m < D; m++) if (uq[m] !== exp_v[m]) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL unsigned_order: got %h..%h required %h..%h (bad %0d)", uq[0], uq[D-1], exp_v[0], exp_v[D-1], bad);
            end
        end
    endtask

    task automatic test_sort_timing();
        int bad;
        int inv;
        for (int pass = 0; pass < 2; pass++) begin
            bit desc = (pass == 0);
            for (int n = 0; n < D; n++) ld[n] = W'(n + 1);
            model(desc, 1'b1);
            inv = inversions(desc, 1'b1);
            run_batch(desc, 1'b0, 1'b0, 1'b0);
            bad = 0;
            for (int m = 0; m < D; m++) if (got[m] !== exp_v[m]) bad++;
            checks++;
            if (bad != 0 || tmo) begin
                errors++;
                $display("FAIL timing_order_desc%0d: got %0d..%0d required %0d..%0d", desc, got[0], got[D-1], exp_v[0], exp_v[D-1]);
            end
            checks++;
            if (sort_cyc != (D - 1) + inv + 1) begin
                errors++;
                $display("FAIL timing_sort_cycles_desc%0d: got %0d required %0d", desc, sort_cyc, D + inv);
            end
`ifdef INSERT_SORT_STATS_EN
            checks++;
            if (int'(swap_count) != inv) begin
                errors++;
                $display("FAIL timing_swap_count_desc%0d: got %0d required %0d", desc, swap_count, inv);
            end
`endif
        end
    endtask

    task automatic test_random_stall();
        int bad;
        int inv;
        bit desc;
        for (int r = 0; r < 6; r++) begin
            for (int n = 0; n < D; n++) ld[n] = $urandom_range(0, 15) - 32'd8;
            desc = 1'($urandom_range(0, 1));
            model(desc, 1'b1);
            inv = inversions(desc, 1'b1);
            run_batch(desc, 1'b1, 1'b1, 1'b0);
            bad = 0;
            for (int m = 0; m < D; m++) if (got[m] !== exp_v[m]) bad++;
            checks++;
            if (bad != 0 || tmo) begin
                errors++;
                $display("FAIL stall%0d_words: %0d wrong words, timeout %b, required 0 wrong", r, bad, tmo);
            end
            checks++;
            if (stall_err != 0) begin
                errors++;
                $display("FAIL stall%0d_hold: got %0d changes under stall required 0", r, stall_err);
            end
            checks++;
            if (last_cnt != 1 || last_pos != D - 1 || !done_ok) begin
                errors++;
                $display("FAIL stall%0d_last_done: last count %0d pos %0d done %b required 1 %0d 1", r, last_cnt, last_pos, done_ok, D - 1);
            end
            checks++;
            if (sort_cyc != D + inv) begin
                errors++;
                $display("FAIL stall%0d_sort_cycles: got %0d required %0d", r, sort_cyc, D + inv);
            end
        end
    endtask

    task automatic test_reset_abort();
        int bad;
        for (int n = 0; n < D; n++) ld[n] = $urandom;
        tmo = 1'b0;
        begin_batch(1'b0);
        load_words(1'b0, 1'b0);
        tick();
        tick();
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_sort_precond: busy %b valid %b ready %b required 1 0 0", busy, out_valid, in_ready);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, out_last, busy, done} !== 5'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL abort_sort_outputs: ctrl %b data %h required 0", {in_ready, out_valid, out_last, busy, done}, out_data);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_sort_release: busy %b valid %b required 0 0", busy, out_valid);
        end

        ld = '{32'd5, 32'd3, 32'd8, 32'd1, 32'd9, 32'd2, 32'd7, 32'd4};
        begin_batch(1'b0);
        load_words(1'b0, 1'b0);
        wait_sort(1'b0);
        drain(1'b0, 1'b0, 3);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL abort_out_precond: out_valid %b required 1", out_valid);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, out_last, busy, done} !== 5'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL abort_out_outputs: ctrl %b data %h required 0", {in_ready, out_valid, out_last, busy, done}, out_data);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_out_release: busy %b valid %b required 0 0", busy, out_valid);
        end

        model(1'b0, 1'b1);
        run_batch(1'b0, 1'b0, 1'b0, 1'b0);
        bad = 0;
        for (int m = 0; m < D; m++) if (got[m] !== exp_v[m]) bad++;
        checks++;
        if (bad != 0 || tmo || !done_ok) begin
            errors++;
            $display("FAIL abort_rerun: %0d wrong words, timeout %b, done %b required 0 0 1", bad, tmo, done_ok);
        end
    endtask

    task automatic test_ignore_controls();
        int bad;
        bit desc;
        for (int r = 0; r < 3; r++) begin
            for (int n = 0; n < D; n++) ld[n] = $urandom;
            desc = 1'($urandom_range(0, 1));
            model(desc, 1'b1);
            run_batch(desc, 1'b1, 1'b0, 1'b1);
            bad = 0;
            for (int m = 0; m < D; m++) if (got[m] !== exp_v[m]) bad++;
            checks++;
            if (bad != 0 || tmo) begin
                errors++;
                $display("FAIL ignore%0d_words: %0d wrong words, timeout %b, required 0", r, bad, tmo);
            end
            checks++;
            if (last_cnt != 1 || !done_ok) begin
                errors++;
                $display("FAIL ignore%0d_last_done: last %0d done %b required 1 1", r, last_cnt, done_ok);
            end
            tick();
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL ignore%0d_idle: busy %b required 0", r, busy);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        descending = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        test_reset();
        test_basic();
        test_signedness();
        test_sort_timing();
        test_random_stall();
        test_reset_abort();
        test_ignore_controls();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
